// File: rtl/fifo_rd_pkg.sv
// Shared types for the fifo_async read-side drain engine.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } rd_state_t;

  localparam int LEN_W_DEFAULT = 16;

endpackage

// File: rtl/fifo_rd_buf.sv
// Small synchronous output buffer with first-word-fall-through head.
module fifo_rd_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   occ_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      occ_q, occ_d;
  logic             do_push_s, do_pop_s;

  // pointer, occupancy and storage next-state
  always_comb begin
    mem_d     = mem_q;
    do_push_s = push_i && (occ_q != (AW+1)'(DEPTH));
    do_pop_s  = pop_i && (occ_q != {(AW+1){1'b0}});
    wr_ptr_d  = wr_ptr_q + AW'(do_push_s);
    rd_ptr_d  = rd_ptr_q + AW'(do_pop_s);
    occ_d     = occ_q + (AW+1)'(do_push_s) - (AW+1)'(do_pop_s);
    if (do_push_s) begin
      mem_d[wr_ptr_q] = push_data_i;
    end else begin
      mem_d = mem_q;
    end
  end

  // buffer state registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      occ_q    <= {(AW+1){1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign valid_o = (occ_q != {(AW+1){1'b0}});
  assign occ_o   = occ_q;

endmodule

// File: rtl/fifo_rd_drain.sv
// Drains an exact word count from fifo_async without reading while empty and
// forwards the words on a valid/ready stream.
module fifo_rd_drain
  import fifo_rd_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int BUF_DEPTH = 4,
  parameter int LEN_W     = LEN_W_DEFAULT
) (
  input  logic             rd_clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             empty_i,
  input  logic [WIDTH-1:0] rdata_i,
  input  logic             rd_error_i,
  output logic             rd_valid_o,
  output logic             m_valid_o,
  output logic [WIDTH-1:0] m_data_o,
  input  logic             m_ready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [LEN_W-1:0] remaining_o,
  output logic             err_o
);

  localparam int OW = $clog2(BUF_DEPTH) + 1;

  rd_state_t        state_q, state_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic             inflight_q, inflight_d;
  logic             err_q, err_d;
  logic [OW-1:0]    occ_s;
  logic [OW:0]      level_s;
  logic             buf_valid_s, pop_s, rd_issue_s;
  logic [WIDTH-1:0] head_s;

  // words already read from the FIFO land here one cycle later
  fifo_rd_buf #(
    .WIDTH (WIDTH),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk_i       (rd_clk_i),
    .rst_i       (rst_i),
    .push_i      (inflight_q),
    .push_data_i (rdata_i),
    .pop_i       (pop_s),
    .head_o      (head_s),
    .valid_o     (buf_valid_s),
    .occ_o       (occ_s)
  );

  // read issue decision and FSM next-state
  always_comb begin
    pop_s       = buf_valid_s && m_ready_i;
    // a read is safe only if its word will find room once the in-flight word lands
    level_s     = {1'b0, occ_s} + (OW+1)'(inflight_q) - (OW+1)'(pop_s);
    rd_issue_s  = (state_q == RUN) && !empty_i && (remaining_q != {LEN_W{1'b0}})
                  && (level_s < (OW+1)'(BUF_DEPTH));
    state_d     = state_q;
    remaining_d = remaining_q;
    inflight_d  = rd_issue_s;
    err_d       = err_q | rd_error_i;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          remaining_d = len_i;
          state_d     = (len_i == {LEN_W{1'b0}}) ? FLUSH : RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (rd_issue_s) begin
          remaining_d = remaining_q - LEN_W'(1);
          state_d     = (remaining_q == LEN_W'(1)) ? FLUSH : RUN;
        end else begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        if (!inflight_q && (occ_s == {OW{1'b0}})) begin
          state_d = DONE;
        end else begin
          state_d = FLUSH;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // control state registers
  always_ff @(posedge rd_clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      remaining_q <= {LEN_W{1'b0}};
      inflight_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      inflight_q  <= inflight_d;
      err_q       <= err_d;
    end
  end

  assign rd_valid_o  = rd_issue_s;
  assign m_valid_o   = buf_valid_s;
  assign m_data_o    = head_s;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);
  assign remaining_o = remaining_q;
  assign err_o       = err_q;

endmodule
